// File: rtl/imm_gen_pkg.sv
// Shared types and the immediate decode function for imm_gen_pipe.
// Compressed formats (codes 8-15) are decoded only when IMM_GEN_PIPE_RVC_EN is defined.
package imm_gen_pkg;

  localparam int IMM_W = 64;

  typedef enum logic [3:0] {
    SEL_R      = 4'd0,
    SEL_I      = 4'd1,
    SEL_S      = 4'd2,
    SEL_B      = 4'd3,
    SEL_U      = 4'd4,
    SEL_J      = 4'd5,
    SEL_Z      = 4'd6,
    SEL_SH     = 4'd7,
    SEL_CI     = 4'd8,
    SEL_CI_LUI = 4'd9,
    SEL_CI16SP = 4'd10,
    SEL_CIW    = 4'd11,
    SEL_CLW    = 4'd12,
    SEL_CSSW   = 4'd13,
    SEL_CB     = 4'd14,
    SEL_CJ     = 4'd15
  } imm_sel_e;

  localparam logic [3:0] RVC_SEL_MIN = 4'd8;

  typedef struct packed {
    logic [IMM_W-1:0] imm;
    logic             err;
  } imm_dec_t;

  // Decodes at the widest XLEN; narrower datapaths keep the low bits, which is exact
  // because every format is sign- or zero-extended from bit 31 or below.
  function automatic imm_dec_t decode_imm(input logic [31:0] inst, input logic [3:0] sel,
                                          input logic is64);
    imm_dec_t r;
    r.imm = {IMM_W{1'b0}};
    r.err = 1'b0;
    case (imm_sel_e'(sel))
      SEL_R:  r.imm = {IMM_W{1'b0}};
      SEL_I:  r.imm = {{52{inst[31]}}, inst[31:20]};
      SEL_S:  r.imm = {{52{inst[31]}}, inst[31:25], inst[11:7]};
      SEL_B:  r.imm = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      SEL_U:  r.imm = {{32{inst[31]}}, inst[31:12], 12'h000};
      SEL_J:  r.imm = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      SEL_Z:  r.imm = {59'd0, inst[19:15]};
      SEL_SH: r.imm = is64 ? {58'd0, inst[25:20]} : {59'd0, inst[24:20]};
`ifdef IMM_GEN_PIPE_RVC_EN
      SEL_CI:     r.imm = {{58{inst[12]}}, inst[12], inst[6:2]};
      SEL_CI_LUI: r.imm = {{46{inst[12]}}, inst[12], inst[6:2], 12'h000};
      SEL_CI16SP: r.imm = {{54{inst[12]}}, inst[12], inst[4:3], inst[5], inst[2], inst[6], 4'h0};
      SEL_CIW:    r.imm = {54'd0, inst[10:7], inst[12:11], inst[5], inst[6], 2'b00};
      SEL_CLW:    r.imm = {57'd0, inst[5], inst[12:10], inst[6], 2'b00};
      SEL_CSSW:   r.imm = {56'd0, inst[8:7], inst[12:9], 2'b00};
      SEL_CB:     r.imm = {{55{inst[12]}}, inst[12], inst[6:5], inst[2], inst[11:10], inst[4:3], 1'b0};
      SEL_CJ:     r.imm = {{52{inst[12]}}, inst[12], inst[8], inst[10:9], inst[6], inst[7],
                           inst[2], inst[11], inst[5:3], 1'b0};
      default:    r.err = 1'b1;
`else
      default: begin
        r.imm = {IMM_W{1'b0}};
        r.err = (sel >= RVC_SEL_MIN);
      end
`endif
    endcase
    return r;
  endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Decode-to-execute beat interface for imm_gen_pipe: request side in, immediate side out.
interface imm_gen_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
);
  logic             valid_i;
  logic             ready_o;
  logic [31:0]      inst_i;
  logic [3:0]       imm_sel_i;
  logic [TAG_W-1:0] tag_i;
  logic             valid_o;
  logic             ready_i;
  logic [XLEN-1:0]  imm_o;
  logic [TAG_W-1:0] tag_o;
  logic             err_o;

  modport slave (
    input  valid_i, inst_i, imm_sel_i, tag_i, ready_i,
    output ready_o, valid_o, imm_o, tag_o, err_o
  );

  modport master (
    output valid_i, inst_i, imm_sel_i, tag_i, ready_i,
    input  ready_o, valid_o, imm_o, tag_o, err_o
  );
endinterface

// File: rtl/imm_skid_buf.sv
// Generic 2-entry valid/ready skid buffer: a main register driving the outputs plus one
// overflow entry, with ready_o taken straight from a flop.
module imm_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [W-1:0] data_o
);

  logic         main_valid_q, main_valid_d;
  logic         skid_valid_q, skid_valid_d;
  logic         ready_q;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         in_acc_s;
  logic         out_acc_s;

  // Next-state for main/skid entries; the skid only fills while the output is stalled.
  always_comb begin
    in_acc_s     = valid_i && ready_q;
    out_acc_s    = main_valid_q && ready_i;
    main_valid_d = main_valid_q;
    main_d       = main_q;
    skid_valid_d = skid_valid_q;
    skid_d       = skid_q;
    if (flush_i) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      main_d       = out_acc_s ? skid_q : main_q;
      skid_valid_d = !out_acc_s;
    end else if (main_valid_q && !ready_i) begin
      skid_d       = in_acc_s ? data_i : skid_q;
      skid_valid_d = in_acc_s;
    end else if (in_acc_s) begin
      main_d       = data_i;
      main_valid_d = 1'b1;
    end else begin
      main_valid_d = 1'b0;
    end
  end

  // State registers; ready is the registered complement of the next skid occupancy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b1;
      main_q       <= {W{1'b0}};
      skid_q       <= {W{1'b0}};
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= !skid_valid_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
    end
  end

  assign ready_o = ready_q;
  assign valid_o = main_valid_q;
  assign data_o  = main_q;

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator: combinational decode_imm feeding a 2-entry skid buffer.
// Define IMM_GEN_PIPE_RVC_EN to enable the compressed-format codes 8-15.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
) (
  input logic          clk_i,
  input logic          rst_i,
  input logic          flush_i,
  imm_gen_pipe_if.slave bus
);

  localparam int   PW   = XLEN + TAG_W + 1;
  localparam logic IS64 = (XLEN == 64);

  imm_dec_t        dec_s;
  logic [PW-1:0]   in_pay_s;
  logic [PW-1:0]   out_pay_s;

  // Decode the offered beat and pack {imm, tag, err} as the buffer payload.
  always_comb begin
    dec_s    = decode_imm(bus.inst_i, bus.imm_sel_i, IS64);
    in_pay_s = {dec_s.imm[XLEN-1:0], bus.tag_i, dec_s.err};
  end

  if (XLEN < IMM_W) begin : g_trunc
    logic unused_hi_s;
    assign unused_hi_s = ^dec_s.imm[IMM_W-1:XLEN];
  end

  imm_skid_buf #(.W(PW)) u_skid (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .valid_i (bus.valid_i),
    .ready_o (bus.ready_o),
    .data_i  (in_pay_s),
    .valid_o (bus.valid_o),
    .ready_i (bus.ready_i),
    .data_o  (out_pay_s)
  );

  assign {bus.imm_o, bus.tag_o, bus.err_o} = out_pay_s;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed self-checking bench for imm_gen_pipe at XLEN=32 and XLEN=64.
// RVC expectations follow IMM_GEN_PIPE_RVC_EN.
module tb_imm_gen_pipe;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   checks   = 0;
  int   failures = 0;

  imm_gen_pipe_if #(.XLEN(32), .TAG_W(4)) b32 ();
  imm_gen_pipe_if #(.XLEN(64), .TAG_W(4)) b64 ();

  imm_gen_pipe #(.XLEN(32), .TAG_W(4)) u_dut32 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .bus(b32.slave));
  imm_gen_pipe #(.XLEN(64), .TAG_W(4)) u_dut64 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .bus(b64.slave));

  always #5 clk = ~clk;

`ifdef IMM_GEN_PIPE_RVC_EN
  localparam logic [31:0] EXP_CI   = 32'hFFFF_FFFF;
  localparam logic [31:0] EXP_CIW  = 32'h0000_0004;
  localparam logic        EXP_RERR = 1'b0;
`else
  localparam logic [31:0] EXP_CI   = 32'h0000_0000;
  localparam logic [31:0] EXP_CIW  = 32'h0000_0000;
  localparam logic        EXP_RERR = 1'b1;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive32(input logic v, input logic [31:0] inst, input logic [3:0] sel,
                         input logic [3:0] tag, input logic rdy);
    b32.valid_i = v; b32.inst_i = inst; b32.imm_sel_i = sel; b32.tag_i = tag; b32.ready_i = rdy;
  endtask

  task automatic drive64(input logic v, input logic [31:0] inst, input logic [3:0] sel,
                         input logic [3:0] tag, input logic rdy);
    b64.valid_i = v; b64.inst_i = inst; b64.imm_sel_i = sel; b64.tag_i = tag; b64.ready_i = rdy;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0;
    drive32(1'b0, 32'h0, 4'd0, 4'd0, 1'b1);
    drive64(1'b0, 32'h0, 4'd0, 4'd0, 1'b1);
    tick(); tick();
    rst = 1'b0;
    checks++; if (b32.valid_o !== 1'b0) begin failures++; $display("FAIL rst_valid32 got=%b exp=0", b32.valid_o); end
    checks++; if (b32.imm_o !== 32'h0) begin failures++; $display("FAIL rst_imm32 got=%h exp=0", b32.imm_o); end
    checks++; if (b32.tag_o !== 4'h0) begin failures++; $display("FAIL rst_tag32 got=%h exp=0", b32.tag_o); end
    checks++; if (b32.err_o !== 1'b0) begin failures++; $display("FAIL rst_err32 got=%b exp=0", b32.err_o); end
    checks++; if (b32.ready_o !== 1'b1) begin failures++; $display("FAIL rst_ready32 got=%b exp=1", b32.ready_o); end
    checks++; if (b64.valid_o !== 1'b0) begin failures++; $display("FAIL rst_valid64 got=%b exp=0", b64.valid_o); end
    checks++; if (b64.ready_o !== 1'b1) begin failures++; $display("FAIL rst_ready64 got=%b exp=1", b64.ready_o); end
  endtask

  task automatic test_decode32();
    drive32(1'b1, 32'hFFF0_0093, 4'd1, 4'd1, 1'b1); tick();
    checks++; if (b32.valid_o !== 1'b1) begin failures++; $display("FAIL lat1_valid got=%b exp=1", b32.valid_o); end
    checks++; if (b32.imm_o !== 32'hFFFF_FFFF) begin failures++; $display("FAIL dec_I got=%h exp=ffffffff", b32.imm_o); end
    checks++; if (b32.tag_o !== 4'd1) begin failures++; $display("FAIL dec_I_tag got=%h exp=1", b32.tag_o); end
    checks++; if (b32.err_o !== 1'b0) begin failures++; $display("FAIL dec_I_err got=%b exp=0", b32.err_o); end
    drive32(1'b1, 32'hFE00_0EE3, 4'd3, 4'd2, 1'b1); tick();
    checks++; if (b32.imm_o !== 32'hFFFF_FFFC) begin failures++; $display("FAIL dec_B got=%h exp=fffffffc", b32.imm_o); end
    checks++; if (b32.tag_o !== 4'd2) begin failures++; $display("FAIL dec_B_tag got=%h exp=2", b32.tag_o); end
    drive32(1'b1, 32'h00A1_2423, 4'd2, 4'd3, 1'b1); tick();
    checks++; if (b32.imm_o !== 32'h0000_0008) begin failures++; $display("FAIL dec_S got=%h exp=8", b32.imm_o); end
    drive32(1'b1, 32'h0080_006F, 4'd5, 4'd4, 1'b1); tick();
    checks++; if (b32.imm_o !== 32'h0000_0008) begin failures++; $display("FAIL dec_J got=%h exp=8", b32.imm_o); end
    drive32(1'b1, 32'hFFFF_FFFF, 4'd0, 4'd5, 1'b1); tick();
    checks++; if (b32.imm_o !== 32'h0) begin failures++; $display("FAIL dec_R got=%h exp=0", b32.imm_o); end
    drive32(1'b1, 32'h03F0_9093, 4'd7, 4'd6, 1'b1); tick();
    checks++; if (b32.imm_o !== 32'h0000_001F) begin failures++; $display("FAIL dec_SH32 got=%h exp=1f", b32.imm_o); end
    drive32(1'b1, 32'h8000_00B7, 4'd4, 4'd7, 1'b1); tick();
    checks++; if (b32.imm_o !== 32'h8000_0000) begin failures++; $display("FAIL dec_U32 got=%h exp=80000000", b32.imm_o); end
    drive32(1'b0, 32'h0, 4'd0, 4'd0, 1'b1); tick();
    checks++; if (b32.valid_o !== 1'b0) begin failures++; $display("FAIL drain32 got=%b exp=0", b32.valid_o); end
  endtask

  task automatic test_decode64();
    drive64(1'b1, 32'h8000_00B7, 4'd4, 4'd1, 1'b1); tick();
    checks++; if (b64.imm_o !== 64'hFFFF_FFFF_8000_0000) begin failures++; $display("FAIL dec_U64 got=%h exp=ffffffff80000000", b64.imm_o); end
    drive64(1'b1, 32'h03F0_9093, 4'd7, 4'd2, 1'b1); tick();
    checks++; if (b64.imm_o !== 64'h3F) begin failures++; $display("FAIL dec_SH64 got=%h exp=3f", b64.imm_o); end
    drive64(1'b1, 32'h1F0F_5073, 4'd6, 4'd3, 1'b1); tick();
    checks++; if (b64.imm_o !== 64'h1E) begin failures++; $display("FAIL dec_Z64 got=%h exp=1e", b64.imm_o); end
    drive64(1'b1, 32'hFFF0_0093, 4'd1, 4'd4, 1'b1); tick();
    checks++; if (b64.imm_o !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL dec_I64 got=%h exp=all ones", b64.imm_o); end
    checks++; if (b64.tag_o !== 4'd4) begin failures++; $display("FAIL dec_I64_tag got=%h exp=4", b64.tag_o); end
    drive64(1'b0, 32'h0, 4'd0, 4'd0, 1'b1); tick();
    checks++; if (b64.valid_o !== 1'b0) begin failures++; $display("FAIL drain64 got=%b exp=0", b64.valid_o); end
  endtask

  task automatic test_rvc();
    drive32(1'b1, 32'h0000_10FD, 4'd8, 4'd9, 1'b1); tick();
    checks++; if (b32.valid_o !== 1'b1) begin failures++; $display("FAIL rvc_valid got=%b exp=1", b32.valid_o); end
    checks++; if (b32.imm_o !== EXP_CI) begin failures++; $display("FAIL rvc_CI got=%h exp=%h", b32.imm_o, EXP_CI); end
    checks++; if (b32.err_o !== EXP_RERR) begin failures++; $display("FAIL rvc_CI_err got=%b exp=%b", b32.err_o, EXP_RERR); end
    drive32(1'b1, 32'h0000_0040, 4'd11, 4'd10, 1'b1); tick();
    checks++; if (b32.imm_o !== EXP_CIW) begin failures++; $display("FAIL rvc_CIW got=%h exp=%h", b32.imm_o, EXP_CIW); end
    checks++; if (b32.err_o !== EXP_RERR) begin failures++; $display("FAIL rvc_CIW_err got=%b exp=%b", b32.err_o, EXP_RERR); end
    drive32(1'b0, 32'h0, 4'd0, 4'd0, 1'b1); tick();
  endtask

  task automatic test_back_to_back();
    logic [3:0] bp_tag [7];
    logic       bp_vld [7];
    logic       bp_rdy [7];
    logic       ex_rdy [7];
    logic       ex_vld [7];
    logic [3:0] ex_tag [7];
    bp_tag = '{4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
    bp_vld = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    bp_rdy = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    ex_rdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    ex_vld = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    ex_tag = '{4'd1, 4'd1, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    for (int i = 0; i < 7; i++) begin
      drive32(bp_vld[i], {8'h00, bp_tag[i], 20'h00013}, 4'd1, bp_tag[i], bp_rdy[i]);
      tick();
      checks++; if (b32.ready_o !== ex_rdy[i]) begin failures++; $display("FAIL bp_ready[%0d] got=%b exp=%b", i, b32.ready_o, ex_rdy[i]); end
      checks++; if (b32.valid_o !== ex_vld[i]) begin failures++; $display("FAIL bp_valid[%0d] got=%b exp=%b", i, b32.valid_o, ex_vld[i]); end
      if (ex_vld[i]) begin
        checks++; if (b32.tag_o !== ex_tag[i]) begin failures++; $display("FAIL bp_tag[%0d] got=%h exp=%h", i, b32.tag_o, ex_tag[i]); end
        checks++; if (b32.imm_o !== {28'd0, ex_tag[i]}) begin failures++; $display("FAIL bp_imm[%0d] got=%h exp=%h", i, b32.imm_o, {28'd0, ex_tag[i]}); end
      end
    end
  endtask

  task automatic test_flush();
    drive32(1'b1, 32'h0050_0013, 4'd1, 4'd5, 1'b0); tick();
    drive32(1'b1, 32'h0060_0013, 4'd1, 4'd6, 1'b0); tick();
    checks++; if (b32.ready_o !== 1'b0) begin failures++; $display("FAIL fl_full got=%b exp=0", b32.ready_o); end
    flush = 1'b1;
    drive32(1'b1, 32'h0070_0013, 4'd1, 4'd7, 1'b0); tick();
    flush = 1'b0;
    checks++; if (b32.valid_o !== 1'b0) begin failures++; $display("FAIL fl_valid got=%b exp=0", b32.valid_o); end
    checks++; if (b32.ready_o !== 1'b1) begin failures++; $display("FAIL fl_ready got=%b exp=1", b32.ready_o); end
    drive32(1'b0, 32'h0, 4'd0, 4'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (b32.valid_o !== 1'b0) begin failures++; $display("FAIL fl_stale[%0d] got=%b tag=%h exp=0", i, b32.valid_o, b32.tag_o); end
    end
    drive32(1'b1, 32'h0090_0013, 4'd1, 4'd9, 1'b0); tick();
    flush = 1'b1;
    drive32(1'b1, 32'h00A0_0013, 4'd1, 4'd10, 1'b0); tick();
    flush = 1'b0;
    checks++; if (b32.valid_o !== 1'b0) begin failures++; $display("FAIL fl_drop got=%b tag=%h exp=0", b32.valid_o, b32.tag_o); end
    drive32(1'b0, 32'h0, 4'd0, 4'd0, 1'b1); tick();
    checks++; if (b32.valid_o !== 1'b0) begin failures++; $display("FAIL fl_drop2 got=%b tag=%h exp=0", b32.valid_o, b32.tag_o); end
    drive32(1'b1, 32'h00B0_0013, 4'd1, 4'd11, 1'b1); tick();
    checks++; if (b32.valid_o !== 1'b1 || b32.tag_o !== 4'd11) begin failures++; $display("FAIL fl_resume got=%b/%h exp=1/b", b32.valid_o, b32.tag_o); end
    drive32(1'b0, 32'h0, 4'd0, 4'd0, 1'b1); tick();
  endtask

  task automatic test_reset_mid();
    drive32(1'b1, 32'h0000_10FD, 4'd8, 4'd3, 1'b0); tick();
    drive32(1'b1, 32'h0000_10FD, 4'd8, 4'd4, 1'b0); tick();
    checks++; if (b32.ready_o !== 1'b0) begin failures++; $display("FAIL rm_full got=%b exp=0", b32.ready_o); end
    rst = 1'b1; flush = 1'b1;
    drive32(1'b0, 32'h0, 4'd0, 4'd0, 1'b0); tick();
    rst = 1'b0; flush = 1'b0; tick();
    checks++; if (b32.valid_o !== 1'b0) begin failures++; $display("FAIL rm_valid got=%b exp=0", b32.valid_o); end
    checks++; if (b32.imm_o !== 32'h0) begin failures++; $display("FAIL rm_imm got=%h exp=0", b32.imm_o); end
    checks++; if (b32.tag_o !== 4'h0) begin failures++; $display("FAIL rm_tag got=%h exp=0", b32.tag_o); end
    checks++; if (b32.err_o !== 1'b0) begin failures++; $display("FAIL rm_err got=%b exp=0", b32.err_o); end
    checks++; if (b32.ready_o !== 1'b1) begin failures++; $display("FAIL rm_ready got=%b exp=1", b32.ready_o); end
  endtask

  initial begin
    test_reset();
    test_decode32();
    test_decode64();
    test_rvc();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
